// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared constants and types for the I2C sequencer slice.
//   - Wishbone register addresses of the I2C controller (CSR, DPR, CMDR)
//   - CSR enable value and CMDR command codes
//   - CMDR status bit positions (DON, NAK, AL, ERR)
//   - response status, FSM state and transfer-kind enums
package i2c_seq_pkg;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;

  // Core enable + interrupt enable.
  localparam logic [7:0] CSR_ENABLE = 8'hC0;

  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_READ_NAK = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h04;
  localparam logic [7:0] CMD_STOP     = 8'h05;
  localparam logic [7:0] CMD_SET_BUS  = 8'h06;

  localparam int CMDR_DON = 7;
  localparam int CMDR_NAK = 6;
  localparam int CMDR_AL  = 5;
  localparam int CMDR_ERR = 4;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_NAK     = 2'b01,
    RSP_ERR     = 2'b10,
    RSP_TIMEOUT = 2'b11
  } rsp_status_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WB_XFER,
    ST_WAIT_IRQ,
    ST_CHECK,
    ST_RESP
  } seq_state_t;

  // What the transfer currently in flight is for.
  typedef enum logic [1:0] {
    XFER_CSR,
    XFER_STEP,
    XFER_STATUS
  } xfer_kind_t;

endpackage

// File: rtl/wb_master_xfer.sv
// wb_master_xfer: one Wishbone classic transfer per start pulse.
//   start_i            : launch a transfer (ignored while one is in flight)
//   addr_i/we_i/wdata_i: sampled together with start_i
//   done_o             : one-cycle pulse, the cycle after cyc_o drops
//   rdata_o            : dat_i captured on the ack cycle
//   cyc_o/stb_o/we_o/adr_o/dat_o, ack_i, dat_i : Wishbone master side
// All bus outputs are flops with async reset, so reset forces them low at once.
module wb_master_xfer #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  output logic          done_o,
  output logic [DW-1:0] rdata_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  input  logic          ack_i,
  input  logic [DW-1:0] dat_i
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      done_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (cyc_o) begin
        if (ack_i) begin
          cyc_o   <= 1'b0;
          stb_o   <= 1'b0;
          we_o    <= 1'b0;
          adr_o   <= '0;
          dat_o   <= '0;
          done_o  <= 1'b1;
          rdata_o <= dat_i;
        end
      end else if (start_i) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= we_i;
        adr_o <= addr_i;
        dat_o <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/i2c_wb_sequencer.sv
// i2c_wb_sequencer: turns a single-byte I2C request into the Wishbone
// register sequence of an I2C controller core and reports the outcome.
//   req_*  : request handshake (valid/ready) with bus, rw, 7-bit addr, wdata
//   rsp_*  : one-cycle response pulse with status and read byte
//   cyc_o..dat_i : Wishbone master port to the controller
//   irq_i  : controller interrupt, awaited after every CMDR command
//
// state       | meaning
// ------------+-----------------------------------------------------------
// INIT        | launch the CSR enable write after reset
// IDLE        | req_ready_o high, waiting for a request
// WB_XFER     | one Wishbone transfer in flight (step, status read or CSR)
// WAIT_IRQ    | command issued, waiting for irq_i with timeout
// CHECK       | decode the CMDR status byte and pick the next step
// RESP        | rsp_valid_o high for this single cycle
module i2c_wb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int NUM_I2C_BUSSES = 6,
  parameter int IRQ_TIMEOUT    = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_bus_i,
  input  logic                     req_rw_i,
  input  logic [6:0]               req_addr_i,
  input  logic [7:0]               req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [1:0]               rsp_status_o,
  output logic [7:0]               rsp_rdata_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     irq_i
);

  localparam int TMO_W = (IRQ_TIMEOUT > 1) ? $clog2(IRQ_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IRQ_TIMEOUT - 1);

  // Command list; steps that write CMDR are followed by an irq wait.
  localparam logic [3:0] STEP_BUS       = 4'd0;
  localparam logic [3:0] STEP_SET_BUS   = 4'd1;
  localparam logic [3:0] STEP_START     = 4'd2;
  localparam logic [3:0] STEP_ADDR      = 4'd3;
  localparam logic [3:0] STEP_ADDR_CMD  = 4'd4;
  localparam logic [3:0] STEP_WDATA     = 4'd5;
  localparam logic [3:0] STEP_WDATA_CMD = 4'd6;
  localparam logic [3:0] STEP_RD_CMD    = 4'd7;
  localparam logic [3:0] STEP_RD_DPR    = 4'd8;
  localparam logic [3:0] STEP_STOP      = 4'd9;

  seq_state_t state;
  xfer_kind_t kind;
  logic [3:0]       step;
  logic [TMO_W-1:0] tmo_cnt;
  logic             xfer_start;
  logic             xfer_done;
  logic [WB_DATA_WIDTH-1:0] xfer_rdata;

  logic [2:0] bus_q;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic [3:0] status_q;   // {DON, NAK, AL, ERR}
  logic [7:0] rd_byte;
  logic       nak_seen;

  logic [WB_ADDR_WIDTH-1:0] x_addr;
  logic                     x_we;
  logic [7:0]               x_byte;
  logic                     step_waits;

  // Transfer parameters are decoded from the registered step/kind, so a
  // start pulse raised together with a step change sees the new step.
  always_comb begin
    x_addr = WB_ADDR_WIDTH'(REG_CMDR);
    x_we   = 1'b1;
    x_byte = 8'h00;
    case (kind)
      XFER_CSR: begin
        x_addr = WB_ADDR_WIDTH'(REG_CSR);
        x_byte = CSR_ENABLE;
      end
      XFER_STATUS: x_we = 1'b0;
      default: begin
        case (step)
          STEP_BUS: begin
            x_addr = WB_ADDR_WIDTH'(REG_DPR);
            x_byte = {5'b0, bus_q};
          end
          STEP_SET_BUS:   x_byte = CMD_SET_BUS;
          STEP_START:     x_byte = CMD_START;
          STEP_ADDR: begin
            x_addr = WB_ADDR_WIDTH'(REG_DPR);
            x_byte = {addr_q, rw_q};
          end
          STEP_ADDR_CMD:  x_byte = CMD_WRITE;
          STEP_WDATA: begin
            x_addr = WB_ADDR_WIDTH'(REG_DPR);
            x_byte = wdata_q;
          end
          STEP_WDATA_CMD: x_byte = CMD_WRITE;
          STEP_RD_CMD:    x_byte = CMD_READ_NAK;
          STEP_RD_DPR: begin
            x_addr = WB_ADDR_WIDTH'(REG_DPR);
            x_we   = 1'b0;
          end
          default:        x_byte = CMD_STOP;
        endcase
      end
    endcase
  end

  assign step_waits = (step == STEP_SET_BUS)  || (step == STEP_START) ||
                      (step == STEP_ADDR_CMD) || (step == STEP_WDATA_CMD) ||
                      (step == STEP_RD_CMD)   || (step == STEP_STOP);

  wb_master_xfer #(
    .AW (WB_ADDR_WIDTH),
    .DW (WB_DATA_WIDTH)
  ) u_xfer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (xfer_start),
    .addr_i  (x_addr),
    .we_i    (x_we),
    .wdata_i (WB_DATA_WIDTH'(x_byte)),
    .done_o  (xfer_done),
    .rdata_o (xfer_rdata),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .ack_i   (ack_i),
    .dat_i   (dat_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_INIT;
      kind         <= XFER_CSR;
      step         <= STEP_BUS;
      tmo_cnt      <= '0;
      xfer_start   <= 1'b0;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= RSP_OK;
      rsp_rdata_o  <= 8'h00;
      bus_q        <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      status_q     <= '0;
      rd_byte      <= '0;
      nak_seen     <= 1'b0;
    end else begin
      xfer_start  <= 1'b0;
      rsp_valid_o <= 1'b0;
      case (state)
        ST_INIT: begin
          kind       <= XFER_CSR;
          xfer_start <= 1'b1;
          state      <= ST_WB_XFER;
        end

        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            bus_q       <= req_bus_i;
            rw_q        <= req_rw_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            nak_seen    <= 1'b0;
            step        <= STEP_BUS;
            if (int'(req_bus_i) >= NUM_I2C_BUSSES) begin
              state        <= ST_RESP;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= RSP_ERR;
              rsp_rdata_o  <= 8'h00;
            end else begin
              kind       <= XFER_STEP;
              xfer_start <= 1'b1;
              state      <= ST_WB_XFER;
            end
          end
        end

        ST_WB_XFER: begin
          if (xfer_done) begin
            case (kind)
              XFER_CSR: begin
                state       <= ST_IDLE;
                req_ready_o <= 1'b1;
              end
              XFER_STATUS: begin
                status_q <= {xfer_rdata[CMDR_DON], xfer_rdata[CMDR_NAK],
                             xfer_rdata[CMDR_AL], xfer_rdata[CMDR_ERR]};
                state    <= ST_CHECK;
              end
              default: begin
                if (step_waits) begin
                  tmo_cnt <= '0;
                  state   <= ST_WAIT_IRQ;
                end else begin
                  if (step == STEP_RD_DPR) rd_byte <= xfer_rdata[7:0];
                  step       <= step + 4'd1;
                  xfer_start <= 1'b1;
                end
              end
            endcase
          end
        end

        ST_WAIT_IRQ: begin
          if (irq_i) begin
            kind       <= XFER_STATUS;
            xfer_start <= 1'b1;
            state      <= ST_WB_XFER;
          end else if (tmo_cnt == TMO_LAST) begin
            state        <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_TIMEOUT;
            rsp_rdata_o  <= 8'h00;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_CHECK: begin
          if (status_q[1] || status_q[0]) begin
            // Arbitration lost or controller error: no STOP.
            state        <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_ERR;
            rsp_rdata_o  <= 8'h00;
          end else if (status_q[2] &&
                       (step == STEP_ADDR_CMD || step == STEP_WDATA_CMD)) begin
            nak_seen   <= 1'b1;
            step       <= STEP_STOP;
            kind       <= XFER_STEP;
            xfer_start <= 1'b1;
            state      <= ST_WB_XFER;
          end else if (!status_q[3]) begin
            // Interrupt without DON (or NAK on a non-data command).
            state        <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_ERR;
            rsp_rdata_o  <= 8'h00;
          end else if (step == STEP_STOP) begin
            state        <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= nak_seen ? RSP_NAK : RSP_OK;
            rsp_rdata_o  <= (rw_q && !nak_seen) ? rd_byte : 8'h00;
          end else begin
            kind       <= XFER_STEP;
            xfer_start <= 1'b1;
            state      <= ST_WB_XFER;
            if (step == STEP_ADDR_CMD)       step <= rw_q ? STEP_RD_CMD : STEP_WDATA;
            else if (step == STEP_WDATA_CMD) step <= STEP_STOP;
            else                             step <= step + 4'd1;
          end
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b1;
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// tb_i2c_wb_sequencer: directed + randomized bench for i2c_wb_sequencer.
// A Wishbone/irq slave model answers the DUT and logs every transfer; the
// expected transfer list and response are built from the request alone.
module tb_i2c_wb_sequencer;

  localparam int NUM_BUS = 6;
  localparam int TMO     = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [2:0] req_bus_i = '0;
  logic       req_rw_i = 1'b0;
  logic [6:0] req_addr_i = '0;
  logic [7:0] req_wdata_i = '0;
  logic       rsp_valid_o;
  logic [1:0] rsp_status_o;
  logic [7:0] rsp_rdata_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic       ack_i = 1'b0;
  logic [7:0] dat_i = '0;
  logic       irq_i = 1'b0;

  always #5 clk_i = ~clk_i;

  i2c_wb_sequencer #(
    .WB_ADDR_WIDTH (2),
    .WB_DATA_WIDTH (8),
    .NUM_I2C_BUSSES(NUM_BUS),
    .IRQ_TIMEOUT   (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_bus_i   (req_bus_i),
    .req_rw_i    (req_rw_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_status_o(rsp_status_o),
    .rsp_rdata_o (rsp_rdata_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .we_o        (we_o),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .ack_i       (ack_i),
    .dat_i       (dat_i),
    .irq_i       (irq_i)
  );

  int checks = 0;
  int failures = 0;

  // Transfer record: {we, adr[1:0], data}; reads carry data 0.
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];

  bit         nak_mode = 0;
  bit         irq_en = 1;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] cmd_status = 8'h80;
  int         wr_since_start = 0;
  int         irq_cd = 0;
  int         ack_wait = 0;
  bit         prev_cyc = 0;
  bit         prev_ack = 0;
  logic [10:0] prev_sig = '0;
  logic [10:0] cur_sig;
  int         proto_err = 0;
  int         cyc_rises = 0;
  int         early_ready = 0;
  bit         init_acked = 0;
  time        last_ack_time = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: random ack latency, CMDR/DPR behaviour, irq after each command.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      ack_i = 1'b0;
      irq_i = 1'b0;
      irq_cd = 0;
      prev_cyc = 0;
      prev_ack = 0;
      init_acked = 0;
    end else begin
      cur_sig = {adr_o, we_o, dat_o};
      if (cyc_o !== stb_o) proto_err++;
      if (cyc_o && prev_ack) proto_err++;
      if (cyc_o && prev_cyc && !prev_ack && cur_sig !== prev_sig) proto_err++;
      if (cyc_o && !prev_cyc) cyc_rises++;
      if (req_ready_o && !init_acked) early_ready++;
      prev_cyc = cyc_o;
      prev_sig = cur_sig;
      if (irq_cd > 0) begin
        irq_cd--;
        if (irq_cd == 0 && irq_en) irq_i = 1'b1;
      end
      if (cyc_o && stb_o && !ack_i) begin
        if (ack_wait > 0) ack_wait--;
        else begin
          ack_i = 1'b1;
          last_ack_time = $time;
          if (we_o) begin
            obs_q.push_back({1'b1, adr_o, dat_o});
            if (adr_o == 2'd0) init_acked = 1;
            if (adr_o == 2'd2) begin
              if (dat_o == 8'h04) wr_since_start = 0;
              if (dat_o == 8'h01) wr_since_start++;
              cmd_status = (nak_mode && dat_o == 8'h01 && wr_since_start == 1) ? 8'h40 : 8'h80;
              irq_cd = $urandom_range(1, 4);
            end
          end else begin
            obs_q.push_back({1'b0, adr_o, 8'h00});
            if (adr_o == 2'd2) begin
              dat_i = cmd_status;
              irq_i = 1'b0;
            end else begin
              dat_i = slave_byte;
            end
          end
        end
      end else begin
        ack_i = 1'b0;
        ack_wait = $urandom_range(0, 2);
      end
      prev_ack = ack_i;
    end
  end

  task automatic push_w(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_r(input logic [1:0] a);
    exp_q.push_back({1'b0, a, 8'h00});
  endtask

  // Reference: expected transfers and response for one request.
  task automatic build_expect(input logic [2:0] bus, input logic rw, input logic [6:0] addr,
                              input logic [7:0] wd, input bit nak, input bit irqen,
                              input logic [7:0] sbyte,
                              output logic [1:0] st, output logic [7:0] rd);
    exp_q.delete();
    st = 2'b00;
    rd = 8'h00;
    if (int'(bus) >= NUM_BUS) begin
      st = 2'b10;
      return;
    end
    push_w(2'd1, {5'b0, bus});
    push_w(2'd2, 8'h06);
    if (!irqen) begin
      st = 2'b11;
      return;
    end
    push_r(2'd2);
    push_w(2'd2, 8'h04); push_r(2'd2);
    push_w(2'd1, {addr, rw});
    push_w(2'd2, 8'h01); push_r(2'd2);
    if (nak) begin
      st = 2'b01;
    end else if (!rw) begin
      push_w(2'd1, wd);
      push_w(2'd2, 8'h01); push_r(2'd2);
    end else begin
      push_w(2'd2, 8'h03); push_r(2'd2);
      push_r(2'd1);
      rd = sbyte;
    end
    push_w(2'd2, 8'h05); push_r(2'd2);
  endtask

  task automatic do_req(input string tag, input logic [2:0] bus, input logic rw,
                        input logic [6:0] addr, input logic [7:0] wd, input bit nak,
                        input bit irqen, input logic [7:0] sbyte);
    logic [1:0] exp_st;
    logic [7:0] exp_rd;
    logic [1:0] got_st;
    logic [7:0] got_rd;
    int n;
    int lat;
    bit got;
    int rises0;
    time t_rsp;
    int wait_cyc;
    build_expect(bus, rw, addr, wd, nak, irqen, sbyte, exp_st, exp_rd);
    @(negedge clk_i);
    obs_q.delete();
    nak_mode = nak;
    irq_en = irqen;
    slave_byte = sbyte;
    rises0 = cyc_rises;
    req_bus_i = bus; req_rw_i = rw; req_addr_i = addr; req_wdata_i = wd;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 200) begin @(negedge clk_i); n++; end
    chk({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    lat = 0; got = 0; got_st = 2'b00; got_rd = 8'h00; t_rsp = 0;
    while (!got && lat < 600) begin
      @(negedge clk_i);
      lat++;
      if (rsp_valid_o) begin
        got = 1; got_st = rsp_status_o; got_rd = rsp_rdata_o; t_rsp = $time;
      end
    end
    chk({tag, "_rsp_seen"}, {31'b0, got}, 32'd1);
    chk({tag, "_status"}, {30'b0, got_st}, {30'b0, exp_st});
    chk({tag, "_rdata"}, {24'b0, got_rd}, {24'b0, exp_rd});
    if (exp_st == 2'b10 && exp_q.size() == 0)
      chk({tag, "_badbus_latency"}, lat, 32'd1);
    if (exp_st == 2'b11) begin
      wait_cyc = int'((t_rsp - last_ack_time) / 10);
      chk({tag, "_timeout_window"}, {31'b0, (wait_cyc >= TMO && wait_cyc <= TMO + 4)}, 32'd1);
    end
    @(negedge clk_i);
    chk({tag, "_rsp_pulse"}, {31'b0, rsp_valid_o}, 32'd0);
    chk({tag, "_xfer_count"}, obs_q.size(), exp_q.size());
    chk({tag, "_cyc_rises"}, cyc_rises - rises0, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), {21'b0, obs_q[i]}, {21'b0, exp_q[i]});
  endtask

  task automatic check_init(input string tag);
    int n;
    logic [10:0] first;
    n = 0;
    while (obs_q.size() == 0 && n < 100) begin @(negedge clk_i); n++; end
    first = (obs_q.size() > 0) ? obs_q[0] : 11'h7FF;
    chk({tag, "_first_xfer"}, {21'b0, first}, {21'b0, 1'b1, 2'd0, 8'hC0});
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clk_i); n++; end
    chk({tag, "_ready_after_ack"}, {31'b0, req_ready_o}, 32'd1);
    chk({tag, "_no_early_ready"}, early_ready, 32'd0);
  endtask

  initial begin
    logic [2:0] r_bus;
    logic       r_rw;
    logic [6:0] r_addr;
    logic [7:0] r_wd;
    logic [7:0] r_sb;
    bit         r_nak;
    int         n;

    repeat (3) @(negedge clk_i);
    chk("reset_outputs",
        {9'b0, cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, rsp_valid_o, rsp_status_o, rsp_rdata_o},
        32'd0);
    rst_i = 1'b1;
    check_init("init");

    do_req("wr_b5", 3'd5, 1'b0, 7'h22, 8'hA5, 0, 1, 8'h00);
    do_req("rd_b0", 3'd0, 1'b1, 7'h22, 8'h00, 0, 1, 8'h3C);
    do_req("nak_addr", 3'd2, 1'b0, 7'h50, 8'h77, 1, 1, 8'h00);
    do_req("nak_rd", 3'd1, 1'b1, 7'h11, 8'h00, 1, 1, 8'h99);
    do_req("bad_bus6", 3'd6, 1'b0, 7'h22, 8'h12, 0, 1, 8'h00);
    do_req("bad_bus7", 3'd7, 1'b1, 7'h05, 8'h00, 0, 1, 8'h00);
    do_req("timeout", 3'd3, 1'b0, 7'h10, 8'h55, 0, 0, 8'h00);

    for (int k = 0; k < 10; k++) begin
      r_bus  = 3'($urandom_range(0, 7));
      r_rw   = 1'($urandom_range(0, 1));
      r_addr = 7'($urandom);
      r_wd   = 8'($urandom);
      r_sb   = 8'($urandom);
      r_nak  = ($urandom_range(0, 3) == 0);
      do_req($sformatf("rnd%0d", k), r_bus, r_rw, r_addr, r_wd, r_nak, 1, r_sb);
    end

    // Reset in the middle of a Wishbone transfer.
    @(negedge clk_i);
    irq_en = 1; nak_mode = 0;
    req_bus_i = 3'd4; req_rw_i = 1'b0; req_addr_i = 7'h33; req_wdata_i = 8'h5A;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 50) begin @(negedge clk_i); n++; end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    n = 0;
    while (!cyc_o && n < 50) begin @(negedge clk_i); n++; end
    chk("midrst_cyc_before", {31'b0, cyc_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_outputs",
        {9'b0, cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, rsp_valid_o, rsp_status_o, rsp_rdata_o},
        32'd0);
    obs_q.delete();
    early_ready = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    check_init("midrst_reinit");
    do_req("post_rst_wr", 3'd1, 1'b0, 7'h2A, 8'hC3, 0, 1, 8'h00);

    chk("wb_protocol", proto_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
